// File: rtl/pcileech_ft601_pkg.sv
// Shared FT601 definitions: frame header layout, idle filler word and framer states.
package pcileech_ft601_pkg;

  localparam logic [15:0] FT601_HDR_MAGIC = 16'hEFFF;
  localparam logic [31:0] FT601_IDLE_WORD = 32'h66665555;

  typedef enum logic [1:0] {
    COLLECT,
    HDR,
    PAYLOAD
  } ft601_framer_state_t;

  typedef struct packed {
    logic [15:0] magic;
    logic [12:0] rsvd;
    logic [2:0]  len;
  } ft601_hdr_t;

  // The magic prefix keeps a header distinct from FT601_IDLE_WORD.
  function automatic logic [31:0] ft601_make_hdr(input logic [2:0] len);
    ft601_hdr_t hdr;
    hdr.magic = FT601_HDR_MAGIC;
    hdr.rsvd  = '0;
    hdr.len   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/pcileech_ft601_tx_framer.sv
// Groups the TX word stream into header+payload frames and feeds the FT601
// controller one word per cycle in which it requests data.
module pcileech_ft601_tx_framer
  import pcileech_ft601_pkg::*;
#(
  parameter int MAX_PAYLOAD = 7,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush,
  output logic [31:0] din,
  output logic        din_wr_en,
  input  logic        din_req_data,
  output logic        busy
);

  localparam logic [3:0] MAX_CNT   = 4'(MAX_PAYLOAD);
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] IDLE_SAT  = 8'(TIMEOUT);

  ft601_framer_state_t state;
  logic [31:0] buf_mem [8];
  logic [3:0]  buf_cnt;
  logic [2:0]  rd_idx;
  logic [7:0]  idle_cnt;

  logic        accept;
  logic [3:0]  cnt_next;
  logic        close_frame;
  logic        last_word;

  // Upstream handshake: a word transfers on a rising edge where s_valid and
  // s_ready are both high; s_valid may not depend on s_ready.
  assign accept   = (state == COLLECT) && s_valid && s_ready;
  assign cnt_next = buf_cnt + {3'b000, accept};

  // A word accepted in the closing cycle is counted into the closing frame.
  assign close_frame = (state == COLLECT) &&
                       ((cnt_next == MAX_CNT) ||
                        ((buf_cnt != 4'd0) && (idle_cnt == IDLE_LAST)) ||
                        (flush && (cnt_next != 4'd0)));

  assign last_word = ({1'b0, rd_idx} == (buf_cnt - 4'd1));

  // Payload storage carries no reset; buf_cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[buf_cnt[2:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      buf_cnt   <= 4'd0;
      rd_idx    <= 3'd0;
      idle_cnt  <= 8'd0;
      din       <= 32'd0;
      din_wr_en <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      din_wr_en <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            buf_cnt  <= cnt_next;
            idle_cnt <= 8'd0;
          end else if ((buf_cnt != 4'd0) && (idle_cnt != IDLE_SAT)) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
          // While collecting, buf_cnt only reaches MAX_CNT in a closing cycle,
          // so s_ready simply tracks whether the frame stays open.
          if (close_frame) begin
            state   <= HDR;
            s_ready <= 1'b0;
            busy    <= 1'b1;
          end else begin
            s_ready <= 1'b1;
          end
        end
        HDR: begin
          if (din_req_data) begin
            din       <= ft601_make_hdr(buf_cnt[2:0]);
            din_wr_en <= 1'b1;
            rd_idx    <= 3'd0;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (din_req_data) begin
            din       <= buf_mem[rd_idx];
            din_wr_en <= 1'b1;
            if (last_word) begin
              buf_cnt  <= 4'd0;
              idle_cnt <= 8'd0;
              rd_idx   <= 3'd0;
              state    <= COLLECT;
              s_ready  <= 1'b1;
              busy     <= 1'b0;
            end else begin
              rd_idx <= rd_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_ft601_tx_framer.sv
// Directed bench for pcileech_ft601_tx_framer: inputs change and outputs are
// observed on the falling edge; every write to the controller port is logged.
module tb_pcileech_ft601_tx_framer;
  import pcileech_ft601_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        flush;
  logic [31:0] din;
  logic        din_wr_en;
  logic        din_req_data;
  logic        busy;

  pcileech_ft601_tx_framer #(.MAX_PAYLOAD(7), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .flush        (flush),
    .din          (din),
    .din_wr_en    (din_wr_en),
    .din_req_data (din_req_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;
  logic [31:0] wr_q[$];
  int          wr_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] ctl_q[$];
  bit          ctl_mode = 1'b0;
  bit          drain_en = 1'b0;
  int          peak     = 0;
  int          ready_viol = 0;
  int          acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: log any write, then advance the controller queue model.
  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    cyc_n++;
    if (din_wr_en) begin
      wr_q.push_back(din);
      wr_cyc.push_back(cyc_n);
      if (s_ready && busy) ready_viol++;
      if (ctl_mode) ctl_q.push_back(din);
    end
    if (ctl_mode) begin
      if (ctl_q.size() > peak) peak = ctl_q.size();
      if (drain_en && ctl_q.size() > 0) begin
        w = ctl_q.pop_front();
        if (exp_q.size() > 0) check("bp_word", w, exp_q.pop_front());
        else check("bp_unexpected_word_count", 32'(exp_q.size()), 32'd1);
      end
      din_req_data = (ctl_q.size() == 2) || (ctl_q.size() == 3);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  task automatic feed(input int n, input logic [31:0] base, input bit flush_last,
                      output int acc_cyc);
    acc_cyc = 0;
    for (int i = 0; i < n; i++) begin
      check("feed_s_ready", 32'(s_ready), 32'd1);
      s_data  = base + 32'(i);
      s_valid = 1'b1;
      flush   = flush_last && (i == n - 1);
      acc_cyc = cyc_n;
      tick();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    s_data  = 32'd0;
  endtask

  task automatic check_frame(input string tag, input int len, input logic [31:0] base,
                             input int hdr_cyc);
    check({tag, "_write_count"}, 32'(wr_q.size()), 32'(len + 1));
    if (wr_q.size() > 0) begin
      check({tag, "_header"}, wr_q[0], 32'hEFFF0000 | 32'(len));
      check({tag, "_header_cycle"}, 32'(wr_cyc[0]), 32'(hdr_cyc));
    end
    for (int i = 0; i < len; i++) begin
      if (i + 1 < wr_q.size()) begin
        check({tag, "_payload"}, wr_q[i + 1], base + 32'(i));
        check({tag, "_payload_cycle"}, 32'(wr_cyc[i + 1]), 32'(hdr_cyc + i + 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; s_data = 32'd0; s_valid = 1'b0; flush = 1'b0; din_req_data = 1'b0;

    // Reset values
    run(3);
    check("rst_din", din, 32'd0);
    check("rst_din_wr_en", 32'(din_wr_en), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("s_ready_after_release", 32'(s_ready), 32'd1);

    // Full 7-word frame with continuous request
    din_req_data = 1'b1;
    clear_log();
    feed(7, 32'h00000001, 1'b0, acc);
    check("full_busy_at_close", 32'(busy), 32'd1);
    check("full_s_ready_at_close", 32'(s_ready), 32'd0);
    run(12);
    check_frame("full", 7, 32'h00000001, acc + 2);
    check("full_s_ready_during_output", 32'(ready_viol), 32'd0);
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_s_ready_after", 32'(s_ready), 32'd1);

    // Idle timeout closes a 3-word frame
    clear_log();
    feed(3, 32'h000000A1, 1'b0, acc);
    run(80);
    check_frame("timeout", 3, 32'h000000A1, acc + 66);

    // Flush on the accept of word 2; later flushes in PAYLOAD and when empty
    clear_log();
    feed(2, 32'h000000B1, 1'b1, acc);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(20);
    check_frame("flush", 2, 32'h000000B1, acc + 2);
    check("flush_busy_after", 32'(busy), 32'd0);

    // Backpressure against a 5-deep controller queue preloaded with 2 words
    clear_log();
    ctl_q.delete();
    exp_q.delete();
    ctl_q.push_back(FT601_IDLE_WORD);
    ctl_q.push_back(FT601_IDLE_WORD);
    exp_q.push_back(32'h66665555);
    exp_q.push_back(32'h66665555);
    exp_q.push_back(32'hEFFF0007);
    for (int i = 0; i < 7; i++) exp_q.push_back(32'h000000C1 + 32'(i));
    peak = 0;
    ctl_mode = 1'b1;
    drain_en = 1'b0;
    din_req_data = 1'b1;
    feed(7, 32'h000000C1, 1'b0, acc);
    run(20);
    check("bp_peak_within_5", 32'(peak <= 5), 32'd1);
    check("bp_stalled_depth", 32'(ctl_q.size()), 32'd4);
    check("bp_stalled_writes", 32'(wr_q.size()), 32'd2);
    drain_en = 1'b1;
    run(40);
    check("bp_peak_after_drain", 32'(peak <= 5), 32'd1);
    check("bp_all_expected_seen", 32'(exp_q.size()), 32'd0);
    check("bp_queue_empty", 32'(ctl_q.size()), 32'd0);
    check("bp_total_writes", 32'(wr_q.size()), 32'd8);
    ctl_mode = 1'b0;
    drain_en = 1'b0;
    din_req_data = 1'b1;

    // Reset after the header and two payload words
    clear_log();
    feed(7, 32'h000000D1, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      if (wr_q.size() >= 3) break;
      tick();
    end
    check("midrst_progress", 32'(wr_q.size()), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_din", din, 32'd0);
    check("midrst_din_wr_en", 32'(din_wr_en), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    clear_log();
    run(3);
    check("midrst_no_write", 32'(wr_q.size()), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_s_ready_release", 32'(s_ready), 32'd1);
    check("midrst_busy_release", 32'(busy), 32'd0);
    clear_log();
    feed(7, 32'h000000E1, 1'b0, acc);
    run(12);
    check_frame("post_rst", 7, 32'h000000E1, acc + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcileech_ft601_tx_framer.md
# pcileech_ft601_tx_framer

Upstream feeder of the FT601 controller's transmit path. It accepts a 32-bit valid/ready word stream from the design's TX FIFO and buffers up to `MAX_PAYLOAD` words. Each group is emitted as a frame: one header word carrying the payload length, then the payload words. Writes into the controller's `din`/`din_wr_en` port are paced by its `din_req_data` request, so the controller's 5-deep output queue never overflows.

## Interface
Parameters:
- `MAX_PAYLOAD`, 7: payload words per frame; legal range 1..7.
- `TIMEOUT`, 64: idle cycles after which a partial frame is flushed; legal range 2..255.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_data`  in  32  upstream word.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  framer accepts `s_data` this cycle.
- `flush`  in  1  single-cycle request to close the current partial frame immediately.
- `din`  out  32  word to FT601 controller.
- `din_wr_en`  out  1  write strobe to FT601 controller.
- `din_req_data`  in  1  controller requests data.
- `busy`  out  1  high while in HDR or PAYLOAD.

## Operation
- **Buffer:** 8×32 register array, `buf_cnt[3:0]`, read index `rd_idx[2:0]`.
- **Header word:** {16'hEFFF, 13'h0000, len[2:0]}, where len = `buf_cnt` at frame close (1..7). Header is never 32'h66665555.

States:
- **COLLECT**
  - `s_ready` = (`buf_cnt` < `MAX_PAYLOAD`).
  - On `s_valid` && `s_ready`: write `buf[buf_cnt]`, increment `buf_cnt`, clear `idle_cnt`.
  - Otherwise, if `buf_cnt` > 0, increment `idle_cnt`, saturating at `TIMEOUT`.
  - Frame closes and the FSM moves to HDR when any of the following holds:
    - `buf_cnt` reaches `MAX_PAYLOAD`, counting a word accepted this cycle;
    - `idle_cnt` == `TIMEOUT`-1 with `buf_cnt` > 0;
    - `flush` && (`buf_cnt` > 0, or a word accepted this cycle).
  - A word accepted in the closing cycle belongs to the closing frame.
  - `flush` with an empty buffer and no accept is ignored.
- **HDR**
  - `s_ready`=0.
  - On a cycle with `din_req_data`=1: register header into `din`, pulse `din_wr_en`, set `rd_idx`=0, go to PAYLOAD.
- **PAYLOAD**
  - `s_ready`=0.
  - On each cycle with `din_req_data`=1: register `buf[rd_idx]`, pulse `din_wr_en`, increment `rd_idx`.
  - After the word at `rd_idx` == len-1 is issued: clear `buf_cnt`, `idle_cnt`, `rd_idx`; return to COLLECT.

Common rules:
- At most one write issued per cycle. A write is issued only in a cycle where `din_req_data` is sampled high.
- `flush` asserted in HDR or PAYLOAD is ignored, not queued.
- **Reset:** asserting `rst_n` low mid-frame aborts immediately. State returns to COLLECT and all counters clear. Buffered words are discarded with no partial frame emitted.

## Timing
- **Reset values:** `din`=0, `din_wr_en`=0, `s_ready`=0, `busy`=0. All counters 0, state COLLECT.
- `s_ready` is held 0 during reset and rises on the first clock edge after `rst_n` deasserts.
- `din` and `din_wr_en` are registered: a request sampled at edge N produces the write visible in cycle N+1.
- **Queue headroom:**
  - The controller's request is high while its queue count is 2 or 3.
  - With one cycle of write latency, at most 3 writes are in flight past the request edge, giving a peak queue depth of 5. This is within the 5-entry queue.
  - No additional throttling is allowed or needed.
- `din_wr_en` is a single-cycle pulse per word. Under a continuous request, words go out back-to-back.
- **Latency:** with `din_req_data` held high, the header write appears 2 cycles after the word that fills the frame is accepted. Payload words follow on consecutive cycles.
- **Timeout:** the close fires exactly `TIMEOUT` cycles after the last accepted word, measured edge to edge.
- `busy` is registered and equals (state != COLLECT).

## Structure
- **Shared package `pcileech_ft601_pkg`:**
  - `FT601_HDR_MAGIC` = 16'hEFFF
  - `FT601_IDLE_WORD` = 32'h66665555
  - `ft601_framer_state_t` enum: COLLECT, HDR, PAYLOAD
  - `ft601_hdr_t` packed struct: magic[15:0], rsvd[12:0], len[2:0]
- No sub-module. The buffer, counters and FSM live in one module, estimated at about 200 lines.

## Test plan
- **Full frame:** feed 7 words 32'h00000001..32'h00000007 back-to-back, `din_req_data`=1 → `din` sequence 32'hEFFF0007, 1..7 on 8 consecutive pulses; `s_ready`=0 throughout output.
- **Timeout:** feed 3 words, then idle with `TIMEOUT`=64 → header 32'hEFFF0003 issued exactly 64 cycles after the last accept plus 2; then 3 payload words.
- **Backpressure:** mirror the controller model (queue 5, drain disabled, request when count is 2 or 3) → count never exceeds 5. When draining resumes, frame order and content are intact.
- **Flush:** 2 words with `flush` asserted on the accept cycle of word 2 → header 32'hEFFF0002. `flush` during PAYLOAD or with an empty buffer → no extra frame.
- **Reset mid-frame:** pull `rst_n` low after the header and 2 payload words → all outputs 0 immediately. After release, `s_ready` rises and the next 7-word input produces a clean frame 32'hEFFF0007.
